// File: rtl/mem_responder.sv
// mem_responder: RAM responder serving fetch and data requesters over req/ack,
// with round-robin tie-breaking and a configurable number of wait states.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              busy_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] rd;
  logic [IDX_W-1:0]  idx;
  logic              grant_d, any_req, enter_resp, in_range;

  // port/last encoding: 1 = data, 0 = fetch; a tie goes to the port not granted last
  assign any_req = if_req_i | d_req_i;
  assign grant_d = d_req_i & (~if_req_i | ~last_q);

  // In IDLE the live inputs are used directly so a zero-wait access can happen on the accept edge
  always_comb begin
    port_d     = state_q == IDLE ? grant_d : port_q;
    we_d       = state_q == IDLE ? grant_d & d_we_i : we_q;
    addr_d     = state_q == IDLE ? (grant_d ? d_addr_i : if_addr_i) : addr_q;
    wdata_d    = state_q == IDLE ? d_wdata_i : wdata_q;
    last_d     = state_q == IDLE && any_req ? grant_d : last_q;
    cnt_d      = state_q == WAIT ? (cnt_q == WS ? cnt_q : cnt_q + 4'd1)
               : state_q == IDLE ? 4'd0 : cnt_q;
    state_d    = state_q == RESP ? IDLE
               : state_q == WAIT ? (cnt_d == WS ? RESP : WAIT)
               : any_req ? (WS == 4'd0 ? RESP : WAIT) : IDLE;
    enter_resp = state_d == RESP && state_q != RESP;
    in_range   = int'(addr_d) < DEPTH;
    idx        = addr_d[IDX_W-1:0];
    rd         = in_range ? mem[idx] : '0;
    if_ack_d   = enter_resp & ~port_d;
    d_ack_d    = enter_resp & port_d;
    if_data_d  = if_ack_d ? rd : if_data_q;
    d_rdata_d  = d_ack_d && !we_d ? rd : d_rdata_q;
  end

  // RAM is deliberately left out of the reset branch so its contents survive reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      port_q    <= port_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_ack_q  <= if_ack_d;
      d_ack_q   <= d_ack_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
      if (d_ack_d && we_d && in_range) mem[idx] <= wdata_d;
    end
  end

  assign if_ack_o  = if_ack_q;
  assign if_data_o = if_data_q;
  assign d_ack_o   = d_ack_q;
  assign d_rdata_o = d_rdata_q;
  assign busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench driving four responder configurations
// (wait states 0/3/2/1, depth 256/256/256/128) through their handshakes.
module tb_mem_responder;
  localparam int N = 4;
  localparam int WS_T [N] = '{0, 3, 2, 1};
  localparam int DP_T [N] = '{256, 256, 256, 128};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       if_req [N];
  logic [7:0] if_addr [N];
  logic       if_ack [N];
  logic [7:0] if_data [N];
  logic       d_req [N];
  logic       d_we [N];
  logic [7:0] d_addr [N];
  logic [7:0] d_wdata [N];
  logic       d_ack [N];
  logic [7:0] d_rdata [N];
  logic       busy [N];

  typedef struct { bit d; bit we; logic [7:0] data; } exp_t;
  exp_t sb [$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.WAIT_STATES(WS_T[g]), .DEPTH(DP_T[g])) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_ack_o(if_ack[g]), .if_data_o(if_data[g]),
      .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_addr_i(d_addr[g]), .d_wdata_i(d_wdata[g]),
      .d_ack_o(d_ack[g]), .d_rdata_o(d_rdata[g]), .busy_o(busy[g])
    );
  end

  // One transaction on instance k; mut alters address/data after the accept edge
  task automatic xact(input int k, input bit d, input bit we, input logic [7:0] addr,
                      input logic [7:0] wd, input logic [7:0] exp, input bit mut);
    int n = 0;
    int nb = 0;
    bit seen = 0;
    exp_t e;
    logic [7:0] prev, got;
    @(negedge clk);
    prev = d_rdata[k];
    sb.push_back('{d: d, we: we, data: exp});
    if (d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      nb += int'(busy[k]);
      seen = if_ack[k] | d_ack[k];
      if (mut && n == 1) begin
        d_addr[k] = addr ^ 8'h01; d_wdata[k] = ~wd;
      end
    end
    d_req[k] = 1'b0; if_req[k] = 1'b0;
    e = sb.pop_front();
    compared++;
    if (!seen || n != WS_T[k] + 1) begin
      mismatched++;
      $display("FAIL latency k%0d @%h: got %0d cycles (ack=%0b) want %0d", k, addr, n, seen, WS_T[k] + 1);
    end
    compared++;
    if (nb != WS_T[k] + 1) begin
      mismatched++;
      $display("FAIL busy_cycles k%0d: got %0d want %0d", k, nb, WS_T[k] + 1);
    end
    compared++;
    if (d_ack[k] !== e.d || if_ack[k] !== !e.d) begin
      mismatched++;
      $display("FAIL ack_port k%0d: got d_ack=%b if_ack=%b want d_ack=%b", k, d_ack[k], if_ack[k], e.d);
    end
    got = e.we ? d_rdata[k] : (e.d ? d_rdata[k] : if_data[k]);
    compared++;
    if (got !== (e.we ? prev : e.data)) begin
      mismatched++;
      $display("FAIL rdata k%0d @%h: got %h want %h", k, addr, got, e.we ? prev : e.data);
    end
    @(posedge clk); #1;
    compared++;
    if (if_ack[k] !== 1'b0 || d_ack[k] !== 1'b0 || busy[k] !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_pulse k%0d: got if_ack=%b d_ack=%b busy=%b want 0 0 0", k, if_ack[k], d_ack[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      compared++;
      if ({if_ack[k], d_ack[k], busy[k], if_data[k], d_rdata[k]} !== 19'd0) begin
        mismatched++;
        $display("FAIL reset k%0d: got ack=%b%b busy=%b if_data=%h d_rdata=%h want zeros",
                 k, if_ack[k], d_ack[k], busy[k], if_data[k], d_rdata[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    xact(0, 1, 1, 8'h10, 8'hA5, 8'h00, 0);
    xact(0, 1, 0, 8'h10, 8'h00, 8'hA5, 0);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int acks = 0;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    if_req[0] = 1; if_addr[0] = 8'h10; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 8'h10;
    for (int i = 0; i < 4; i++) sb.push_back('{d: (i % 2 == 0), we: 1'b0, data: 8'hA5});
    @(negedge clk);
    rst_n = 1'b1;
    while (acks < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      compared++;
      if (if_ack[0] && d_ack[0]) begin
        mismatched++;
        $display("FAIL dual_ack cycle %0d: got if_ack=1 d_ack=1 want at most one", n);
      end
      if (if_ack[0] || d_ack[0]) begin
        e = sb.pop_front();
        compared++;
        if (d_ack[0] !== e.d || (e.d ? d_rdata[0] : if_data[0]) !== e.data) begin
          mismatched++;
          $display("FAIL grant_order #%0d: got d_ack=%b data=%h want d_ack=%b data=%h",
                   acks, d_ack[0], e.d ? d_rdata[0] : if_data[0], e.d, e.data);
        end
        acks++;
      end
    end
    if_req[0] = 0; d_req[0] = 0;
    compared++;
    if (acks != 4) begin
      mismatched++;
      $display("FAIL grant_timeout: got %0d acks want 4", acks);
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wait_fetch();
    xact(1, 1, 1, 8'h00, 8'h21, 8'h00, 0);
    xact(1, 0, 0, 8'h00, 8'h00, 8'h21, 0);
  endtask

  task automatic test_latch();
    xact(2, 1, 1, 8'h41, 8'h44, 8'h00, 0);
    xact(2, 1, 1, 8'h40, 8'h77, 8'h00, 1);
    xact(2, 1, 0, 8'h40, 8'h00, 8'h77, 0);
    xact(2, 1, 0, 8'h41, 8'h00, 8'h44, 0);
  endtask

  task automatic test_out_of_range();
    xact(3, 1, 1, 8'h00, 8'h3C, 8'h00, 0);
    xact(3, 1, 1, 8'h80, 8'h55, 8'h00, 0);
    xact(3, 1, 0, 8'h80, 8'h00, 8'h00, 0);
    xact(3, 0, 0, 8'hC0, 8'h00, 8'h00, 0);
    xact(3, 1, 0, 8'h00, 8'h00, 8'h3C, 0);
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    xact(1, 1, 1, 8'h20, 8'h11, 8'h00, 0);
    xact(1, 1, 0, 8'h20, 8'h00, 8'h11, 0);
    @(negedge clk);
    d_req[1] = 1; d_we[1] = 1; d_addr[1] = 8'h20; d_wdata[1] = 8'hEE;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({if_ack[1], d_ack[1], busy[1], if_data[1], d_rdata[1]} !== 19'd0) begin
      mismatched++;
      $display("FAIL abort_outputs: got ack=%b%b busy=%b if_data=%h d_rdata=%h want zeros",
               if_ack[1], d_ack[1], busy[1], if_data[1], d_rdata[1]);
    end
    d_req[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      acks += int'(if_ack[1] | d_ack[1]);
    end
    compared++;
    if (acks != 0) begin
      mismatched++;
      $display("FAIL abort_ack: got %0d acks want 0", acks);
    end
    xact(1, 1, 0, 8'h20, 8'h00, 8'h11, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wait_fetch();
    test_latch();
    test_out_of_range();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
